fpga_cfg_seq: RTL and testbench

FPGA_CFG_SEQ -- requirements
Module: fpga_cfg_seq

---
 rtl/fpga_cfg_pkg.sv | 25 ++
 rtl/cfg_shifter.sv | 74 +++++++
 rtl/fpga_cfg_seq.sv | 159 +++++++++++++++
 tb/tb_fpga_cfg_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the passive-serial FPGA configuration sequencer:
// FSM state encoding and default timing parameters.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_WAIT_ST = 3'd2,
    S_LOAD    = 3'd3,
    S_INIT    = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  localparam int CFG_LOW_CYC_DEF = 20;
  localparam int ST_TMO_DEF      = 1000;
  localparam int INIT_TMO_DEF    = 4096;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_shifter.sv
// Passive-serial byte shifter: LSB first, two clocks per bit (dclk low with
// data valid, then dclk high), busy for the 16 cycles of a byte.
module cfg_shifter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       dclk_o,
  output logic       data0_o,
  output logic       busy_o
);

  logic [7:0] sr_q;
  logic [3:0] ph_q, ph_d;
  logic       busy_q, busy_d;
  logic       dclk_q, dclk_d;
  logic       data0_q, data0_d;

  always_comb begin
    busy_d  = busy_q;
    dclk_d  = dclk_q;
    data0_d = data0_q;
    ph_d    = ph_q;
    if (clr_i) begin
      busy_d  = 1'b0;
      dclk_d  = 1'b0;
      data0_d = 1'b0;
      ph_d    = 4'd0;
    end else if (load_i) begin
      busy_d  = 1'b1;
      dclk_d  = 1'b0;
      data0_d = data_i[0];
      ph_d    = 4'd0;
    end else if (busy_q) begin
      ph_d = ph_q + 4'd1;
      if (!ph_q[0]) begin
        dclk_d = 1'b1;
      end else begin
        // Falling dclk: present the next bit, or release after bit 7.
        dclk_d = 1'b0;
        if (ph_q == 4'd15) begin
          busy_d  = 1'b0;
          data0_d = 1'b0;
        end else begin
          data0_d = sr_q[ph_q[3:1] + 3'd1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      dclk_q  <= 1'b0;
      data0_q <= 1'b0;
      ph_q    <= 4'd0;
    end else begin
      busy_q  <= busy_d;
      dclk_q  <= dclk_d;
      data0_q <= data0_d;
      ph_q    <= ph_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) sr_q <= data_i;
  end

  assign dclk_o  = dclk_q;
  assign data0_o = data0_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/fpga_cfg_seq.sv
// FPGA passive-serial configuration sequencer: nCONFIG pulse, status
// handshake, byte loading through cfg_shifter, init wait and error handling.
module fpga_cfg_seq
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_LOW_CYC = CFG_LOW_CYC_DEF,
  parameter int ST_TMO      = ST_TMO_DEF,
  parameter int INIT_TMO    = INIT_TMO_DEF
) (
  input  logic       clkin,
  input  logic       coldres_n,
  input  logic       cmd_start,
  input  logic       cmd_abort,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       status_n,
  input  logic       conf_done,
  input  logic       init_done,
  output logic       config_n,
  output logic       dclk,
  output logic       data0,
  output logic       busy,
  output logic [2:0] state,
  output logic       err,
  output logic       ovr,
  output logic       cfg_ok,
  output logic       cpld_off
);

  localparam int CNT_MAX = max3(CFG_LOW_CYC, ST_TMO, INIT_TMO);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(CFG_LOW_CYC - 1);
  localparam logic [CW-1:0] ST_LAST   = CW'(ST_TMO - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TMO - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          config_n_q, config_n_d;
  logic          cfg_ok_q, cfg_ok_d;
  logic          low_seen;
  logic          sh_busy, sh_load, sh_clr;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    low_seen = seen_q | ~status_n;
    if (cmd_abort) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    if (cmd_start) state_d = S_PULSE;
        S_PULSE: begin
          // The FPGA must have acknowledged nCONFIG low at some point.
          if (cnt_q == LOW_LAST) begin
            if (low_seen) state_d = S_WAIT_ST;
            else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
        end
        S_WAIT_ST: begin
          if (status_n) state_d = S_LOAD;
          else if (cnt_q == ST_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        S_LOAD: begin
          if (!status_n) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if ((conf_done | pend_q) && !sh_busy) begin
            state_d = S_INIT;
          end
          if (wr_stb && sh_busy) ovr_d = 1'b1;
        end
        S_INIT: begin
          if (init_done) state_d = S_DONE;
          else if (cnt_q == INIT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        S_DONE:    ;
        S_ERROR: begin
          if (cmd_start) begin
            state_d = S_PULSE;
            err_d   = 1'b0;
            ovr_d   = 1'b0;
          end
        end
        default:   state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == '1)    cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_ONE;

    // conf_done seen mid-byte is remembered until the byte finishes.
    seen_d     = (state_q == S_PULSE) && (state_d == S_PULSE) && low_seen;
    pend_d     = (state_q == S_LOAD) && (state_d == S_LOAD) && (pend_q | conf_done);
    sh_clr     = (state_d != S_LOAD);
    sh_load    = (state_q == S_LOAD) && (state_d == S_LOAD) && wr_stb && !sh_busy;
    config_n_d = (state_d != S_PULSE);
    cfg_ok_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clkin or negedge coldres_n) begin
    if (!coldres_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      config_n_q <= 1'b1;
      cfg_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      config_n_q <= config_n_d;
      cfg_ok_q   <= cfg_ok_d;
    end
  end

  cfg_shifter u_shifter (
    .clk_i   (clkin),
    .rst_ni  (coldres_n),
    .clr_i   (sh_clr),
    .load_i  (sh_load),
    .data_i  (wr_data),
    .dclk_o  (dclk),
    .data0_o (data0),
    .busy_o  (sh_busy)
  );

  assign config_n = config_n_q;
  assign busy     = sh_busy;
  assign state    = state_q;
  assign err      = err_q;
  assign ovr      = ovr_q;
  assign cfg_ok   = cfg_ok_q;
  assign cpld_off = cfg_ok_q;

endmodule

// File: tb/tb_fpga_cfg_seq.sv
// Bench for fpga_cfg_seq: directed table, multi-cycle scenarios and random
// stimulus, all checked against a behavioural model every cycle.
`timescale 1ns/1ps
module tb_fpga_cfg_seq;

  localparam int CFG_LOW  = 20;
  localparam int ST_TMO   = 1000;
  localparam int INIT_TMO = 4096;

  logic       clkin = 1'b0;
  logic       coldres_n = 1'b0;
  logic       cmd_start = 1'b0, cmd_abort = 1'b0, wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       st_man = 1'b1, fpga_auto = 1'b0, st_auto = 1'b1, glitch = 1'b0;
  logic       conf_done = 1'b0, init_done = 1'b0;
  logic       status_n;
  logic       config_n, dclk, data0, busy, err, ovr, cfg_ok, cpld_off;
  logic [2:0] state;

  assign status_n = fpga_auto ? (st_auto ^ glitch) : st_man;

  fpga_cfg_seq dut (
    .clkin(clkin), .coldres_n(coldres_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .wr_stb(wr_stb), .wr_data(wr_data), .status_n(status_n), .conf_done(conf_done),
    .init_done(init_done), .config_n(config_n), .dclk(dclk), .data0(data0), .busy(busy),
    .state(state), .err(err), .ovr(ovr), .cfg_ok(cfg_ok), .cpld_off(cpld_off)
  );

  always #50 clkin = ~clkin;

  // FPGA status pin: low while nCONFIG is low, high 10 cycles after release.
  int rise_n = 10;
  always @(negedge clkin) begin
    if (!config_n) begin
      st_auto = 1'b0;
      rise_n  = 0;
    end else if (rise_n < 10) begin
      rise_n++;
      if (rise_n == 10) st_auto = 1'b1;
    end
  end

  int dclk_n = 0;
  bit capq[$];
  always @(posedge dclk) begin
    dclk_n++;
    capq.push_back(data0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as a number, shifter as progress index m_k
  // through the 16 half-bit slots of the current byte (-1 when idle).
  int       m_st, m_age, m_k;
  bit       m_seen, m_pend, m_err, m_ovr;
  logic [7:0] m_byte;

  task automatic model_reset();
    m_st = 0; m_age = 0; m_k = -1;
    m_seen = 0; m_pend = 0; m_err = 0; m_ovr = 0; m_byte = 8'h00;
  endtask

  task automatic model_step();
    int nx;
    bit mb, low;
    nx  = m_st;
    mb  = (m_k >= 0);
    low = m_seen || !status_n;
    if (cmd_abort) begin
      nx = 0; m_err = 0; m_ovr = 0;
    end else begin
      case (m_st)
        0: if (cmd_start) nx = 1;
        1: if (m_age == CFG_LOW - 1) begin
             if (low) nx = 2;
             else begin nx = 6; m_err = 1; end
           end
        2: if (status_n) nx = 3;
           else if (m_age == ST_TMO - 1) begin nx = 6; m_err = 1; end
        3: begin
             if (!status_n) begin nx = 6; m_err = 1; end
             else if ((conf_done || m_pend) && !mb) nx = 4;
             if (wr_stb && mb) m_ovr = 1;
           end
        4: if (init_done) nx = 5;
           else if (m_age == INIT_TMO - 1) begin nx = 6; m_err = 1; end
        6: if (cmd_start) begin nx = 1; m_err = 0; m_ovr = 0; end
        default: ;
      endcase
    end
    if (nx != 3) m_k = -1;
    else if (m_st == 3 && wr_stb && !mb) begin m_k = 0; m_byte = wr_data; end
    else if (mb) m_k = (m_k == 15) ? -1 : m_k + 1;
    m_pend = (m_st == 3 && nx == 3) && (m_pend || conf_done);
    m_seen = (m_st == 1 && nx == 1) && low;
    m_age  = (nx != m_st) ? 0 : m_age + 1;
    m_st   = nx;
  endtask

  task automatic model_compare();
    logic [10:0] e, a;
    bit b;
    b = (m_k >= 0);
    e = {m_st != 1, b && (m_k % 2 == 1), b ? m_byte[m_k / 2] : 1'b0, b, 3'(m_st),
         m_err, m_ovr, m_st == 5, m_st == 5};
    a = {config_n, dclk, data0, busy, state, err, ovr, cfg_ok, cpld_off};
    chk("model_cycle", 32'(a), 32'(e));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clkin);
      if (coldres_n) model_step();
      @(negedge clkin);
      if (coldres_n) model_compare();
    end
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1; cyc(1); cmd_start = 1'b0;
  endtask

  task automatic pulse_abort();
    cmd_abort = 1'b1; cyc(1); cmd_abort = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_stb = 1'b1; wr_data = d; cyc(1); wr_stb = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int i;
    i = 0;
    while (state !== s && i < lim) begin cyc(1); i++; end
    chk(nm, 32'(state), 32'(s));
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < lim) begin cyc(1); i++; end
    chk(nm, 32'(busy), 32'(0));
  endtask

  typedef struct {
    bit         start;
    bit         abort;
    bit         stn;
    int         hold;
    logic [2:0] est;
    bit         eerr;
    bit         ecfgn;
  } row_t;

  row_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_n, base, d0;
    logic [15:0] expbits;

    tbl[0]  = '{0, 1, 1, 1,   3'd0, 0, 1};
    tbl[1]  = '{1, 0, 1, 20,  3'd1, 0, 0};
    tbl[2]  = '{0, 0, 1, 1,   3'd6, 1, 1};
    tbl[3]  = '{1, 0, 0, 1,   3'd1, 0, 0};
    tbl[4]  = '{0, 0, 0, 19,  3'd1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1,   3'd2, 0, 1};
    tbl[6]  = '{0, 0, 0, 999, 3'd2, 0, 1};
    tbl[7]  = '{0, 0, 0, 1,   3'd6, 1, 1};
    tbl[8]  = '{1, 0, 0, 21,  3'd2, 0, 1};
    tbl[9]  = '{0, 0, 1, 1,   3'd3, 0, 1};
    tbl[10] = '{1, 0, 1, 1,   3'd3, 0, 1};
    tbl[11] = '{0, 1, 1, 1,   3'd0, 0, 1};
    tbl[12] = '{1, 1, 1, 1,   3'd0, 0, 1};
    tbl[13] = '{1, 0, 1, 1,   3'd1, 0, 0};
    tbl[14] = '{0, 1, 1, 1,   3'd0, 0, 1};

    model_reset();
    cyc(2);
    chk("reset_outputs", 32'({config_n, dclk, data0, busy, state, err, ovr, cfg_ok, cpld_off}),
        32'(11'b100_0000_0000));
    coldres_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 15; i++) begin
      st_man    = tbl[i].stn;
      cmd_start = tbl[i].start;
      cmd_abort = tbl[i].abort;
      cyc(1);
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      if (tbl[i].hold > 1) cyc(tbl[i].hold - 1);
      chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].est));
      chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].eerr));
      chk($sformatf("row%0d_config_n", i), 32'(config_n), 32'(tbl[i].ecfgn));
    end

    // Normal configuration flow.
    st_man = 1'b1;
    fpga_auto = 1'b1;
    pulse_start();
    low_n = (config_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (!config_n) low_n++;
    end
    chk("normal_config_low_cycles", 32'(low_n), 32'(CFG_LOW));
    wait_state(3'd3, 50, "normal_reach_load");
    base = capq.size();
    write_byte(8'hA5);
    wait_idle(40, "normal_byte1_done");
    write_byte(8'h3C);
    wait_idle(40, "normal_byte2_done");
    chk("normal_dclk_pulses", 32'(capq.size() - base), 32'(16));
    expbits = {8'h3C, 8'hA5};
    for (int i = 0; i < 16; i++)
      if (base + i < capq.size())
        chk($sformatf("normal_data0_bit%0d", i), 32'(capq[base + i]), 32'(expbits[i]));
    conf_done = 1'b1;
    wait_state(3'd4, 5, "normal_reach_init");
    init_done = 1'b1;
    wait_state(3'd5, 5, "normal_reach_done");
    conf_done = 1'b0;
    init_done = 1'b0;
    cyc(3);
    chk("normal_cfg_ok", 32'(cfg_ok), 32'(1));
    chk("normal_cpld_off", 32'(cpld_off), 32'(1));
    chk("normal_done_held", 32'(state), 32'(5));
    pulse_abort();
    chk("abort_clears_cfg_ok", 32'(cfg_ok), 32'(0));

    // Overrun: second write four cycles after the first.
    pulse_start();
    wait_state(3'd3, 60, "ovr_reach_load");
    d0 = dclk_n;
    write_byte(8'h5A);
    cyc(3);
    write_byte(8'hFF);
    chk("ovr_set", 32'(ovr), 32'(1));
    wait_idle(40, "ovr_byte_done");
    cyc(5);
    chk("ovr_dclk_pulses", 32'(dclk_n - d0), 32'(8));
    chk("ovr_sticky", 32'(ovr), 32'(1));
    pulse_abort();
    chk("abort_clears_ovr", 32'(ovr), 32'(0));

    // conf_done mid-byte, then init timeout.
    pulse_start();
    wait_state(3'd3, 60, "cd_reach_load");
    d0 = dclk_n;
    write_byte(8'hC3);
    cyc(5);
    conf_done = 1'b1;
    cyc(1);
    chk("cd_stays_load_while_busy", 32'(state), 32'(3));
    wait_state(3'd4, 30, "cd_reach_init");
    chk("cd_dclk_pulses", 32'(dclk_n - d0), 32'(8));
    conf_done = 1'b0;
    cyc(INIT_TMO - 1);
    chk("init_tmo_not_yet", 32'(state), 32'(4));
    cyc(1);
    chk("init_tmo_state", 32'(state), 32'(6));
    chk("init_tmo_err", 32'(err), 32'(1));

    // Abort and start together mid-byte.
    pulse_start();
    chk("restart_clears_err", 32'(err), 32'(0));
    wait_state(3'd3, 60, "ab_reach_load");
    write_byte(8'h81);
    cyc(3);
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    cyc(1);
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    chk("ab_state", 32'(state), 32'(0));
    chk("ab_busy", 32'(busy), 32'(0));
    chk("ab_config_n", 32'(config_n), 32'(1));

    // Cold reset mid-byte.
    pulse_start();
    wait_state(3'd3, 60, "rst_reach_load");
    write_byte(8'hE7);
    cyc(4);
    #10;
    coldres_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_outputs", 32'({config_n, dclk, data0, busy, state, err, ovr, cfg_ok, cpld_off}),
        32'(11'b100_0000_0000));
    d0 = dclk_n;
    cyc(3);
    coldres_n = 1'b1;
    cyc(40);
    chk("rst_no_dclk", 32'(dclk_n - d0), 32'(0));
    chk("rst_idle", 32'(state), 32'(0));

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      cmd_start = ($urandom_range(0, 29) == 0);
      cmd_abort = ($urandom_range(0, 249) == 0);
      wr_stb    = ($urandom_range(0, 3) == 0);
      wr_data   = 8'($urandom);
      glitch    = ($urandom_range(0, 199) == 0);
      conf_done = ($urandom_range(0, 39) == 0);
      init_done = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    cmd_start = 1'b0; cmd_abort = 1'b0; wr_stb = 1'b0;
    glitch = 1'b0; conf_done = 1'b0; init_done = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
